sma_decim_fifo: RTL



---
 rtl/sma_decim_fifo_if.sv | 26 ++
 rtl/sma_decim_fifo.sv | 106 ++++++++++
 2 files changed

// File: rtl/sma_decim_fifo_if.sv
// Sample-stream bus for the decimating FIFO: filtered samples in, FWFT drain out, overflow status.
interface sma_decim_fifo_if #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 8
);
   localparam int unsigned LW = $clog2(DEPTH) + 1;

   logic signed [WIDTH-1:0] in_data;
   logic                    in_valid;
   logic signed [WIDTH-1:0] out_data;
   logic                    out_valid;
   logic                    out_ready;
   logic [LW-1:0]           level;
   logic                    ovf;
   logic                    ovf_clr;

   modport master (
      output in_data, in_valid, out_ready, ovf_clr,
      input  out_data, out_valid, level, ovf
   );

   modport slave (
      input  in_data, in_valid, out_ready, ovf_clr,
      output out_data, out_valid, level, ovf
   );
endinterface

// File: rtl/sma_decim_fifo.sv
// Keeps every DECIM-th valid filtered sample and buffers it in a first-word-fall-through FIFO
// with registered head data, occupancy counter and a sticky drop flag.
module sma_decim_fifo #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DECIM = 4,
   parameter int unsigned DEPTH = 8
) (
   input logic              clk,
   input logic              rst,
   sma_decim_fifo_if.slave  bus
);
   localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned LW  = $clog2(DEPTH) + 1;
   localparam int unsigned PHW = (DECIM > 1) ? $clog2(DECIM) : 1;

   localparam logic [PHW-1:0] PH_LAST  = PHW'(DECIM - 1);
   localparam logic [LW-1:0]  LVL_FULL = LW'(DEPTH);

   logic [PHW-1:0]          phase_q,    phase_d;
   logic [PW-1:0]           wr_ptr_q,   wr_ptr_d;
   logic [PW-1:0]           rd_ptr_q,   rd_ptr_d;
   logic [LW-1:0]           level_q,    level_d;
   logic                    out_valid_q, out_valid_d;
   logic signed [WIDTH-1:0] out_data_q, out_data_d;
   logic                    ovf_q,      ovf_d;
   logic signed [WIDTH-1:0] mem_q [DEPTH];

   logic keep_c;
   logic pop_c;
   logic push_c;
   logic drop_c;

   // Handshake decode: a full FIFO still accepts a push when the head leaves in the same cycle
   always_comb begin
      pop_c  = out_valid_q & bus.out_ready;
      keep_c = bus.in_valid & (phase_q == PH_LAST);
      push_c = keep_c & ((level_q != LVL_FULL) | pop_c);
      drop_c = keep_c & ~push_c;
   end

   always_comb begin
      phase_d     = phase_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      level_d     = level_q;
      ovf_d       = ovf_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;

      if (bus.in_valid) begin
         phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PHW'(1);
      end

      if (push_c) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + PW'(1);

      unique case ({push_c, pop_c})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase

      // A drop in the same cycle as a clear keeps the flag set
      if (drop_c)           ovf_d = 1'b1;
      else if (bus.ovf_clr) ovf_d = 1'b0;

      out_valid_d = (level_d != '0);

      // Next head: bypass the incoming sample when it lands in the head slot
      if (push_c && (wr_ptr_q == rd_ptr_d)) begin
         out_data_d = bus.in_data;
      end else if (out_valid_d) begin
         out_data_d = mem_q[rd_ptr_d];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_q     <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         ovf_q       <= 1'b0;
      end else begin
         phase_q     <= phase_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         ovf_q       <= ovf_d;
      end
   end

   // Storage array carries no reset; occupancy alone decides what is valid
   always_ff @(posedge clk) begin
      if (push_c) mem_q[wr_ptr_q] <= bus.in_data;
   end

   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;
   assign bus.level     = level_q;
   assign bus.ovf       = ovf_q;
endmodule
